md_sequencer: RTL and testbench



---
 rtl/md_sequencer_pkg.sv | 33 +++
 rtl/md_arith.sv | 62 ++++++
 rtl/md_sequencer.sv | 114 +++++++++++
 tb/tb_md_sequencer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/md_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer_pkg
// Purpose  : Shared opcode encodings, FSM states and default latencies for
//            the E-stage multiply/divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package md_sequencer_pkg;

    // md_op encodings (6/7 are no-ops)
    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    // Default busy latencies
    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // True for the multi-cycle ops (MULT/MULTU/DIV/DIVU)
    function automatic logic is_long_op(input logic [2:0] op);
        return (op <= MD_DIVU);
    endfunction

endpackage : md_sequencer_pkg
`default_nettype wire

// File: rtl/md_arith.sv
`default_nettype none
// ============================================================================
// Module   : md_arith
// Purpose  : Combinational multiply/divide datapath. Produces {hi,lo} from
//            latched operands; owns signedness, divide-by-zero and signed
//            overflow rules.
// Revision : 1.0 - initial release
// ============================================================================
module md_arith
    import md_sequencer_pkg::*;
(
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] result_o
);

    logic               w_div_zero;
    logic               w_div_ovf;
    logic [31:0]        w_b_safe;
    logic signed [63:0] w_prod_s;
    logic [63:0]        w_prod_u;
    logic signed [31:0] w_quot_s;
    logic signed [31:0] w_rem_s;
    logic [31:0]        w_quot_u;
    logic [31:0]        w_rem_u;

    assign w_div_zero = (b_i == 32'd0);
    // Only the signed divide can overflow (most negative / -1)
    assign w_div_ovf  = (op_i == MD_DIV) && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    // Special cases are muxed out below; keep the divider away from them
    assign w_b_safe   = (w_div_zero || w_div_ovf) ? 32'd1 : b_i;

    assign w_prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    assign w_prod_u = {32'd0, a_i} * {32'd0, b_i};
    // SystemVerilog signed divide truncates; remainder follows the dividend sign
    assign w_quot_s = $signed(a_i) / $signed(w_b_safe);
    assign w_rem_s  = $signed(a_i) % $signed(w_b_safe);
    assign w_quot_u = a_i / w_b_safe;
    assign w_rem_u  = a_i % w_b_safe;

    // Select the {hi,lo} pair for the latched op
    always_comb begin
        result_o = 64'd0;
        case (op_i)
            MD_MULT:  result_o = w_prod_s;
            MD_MULTU: result_o = w_prod_u;
            MD_DIV: begin
                if (w_div_zero)     result_o = {a_i, 32'hFFFF_FFFF};
                else if (w_div_ovf) result_o = {32'd0, 32'h8000_0000};
                else                result_o = {w_rem_s, w_quot_s};
            end
            MD_DIVU: begin
                if (w_div_zero)     result_o = {a_i, 32'hFFFF_FFFF};
                else                result_o = {w_rem_u, w_quot_u};
            end
            default:  result_o = 64'd0;
        endcase
    end

endmodule : md_arith
`default_nettype wire

// File: rtl/md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : md_sequencer
// Purpose  : E-stage multiply/divide sequencer. Latches operands on start,
//            stays busy for a fixed latency, commits HI/LO and raises the
//            stall request for the hazard unit.
// Revision : 1.0 - initial release
// ============================================================================
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        d_md_use,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    md_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       op_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic             busy_q;
    logic [63:0]      w_result;
    logic [CNT_W-1:0] cnt_d;

    md_arith u_arith (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (w_result)
    );

    // Latency loaded on a start; op bit 1 separates divide from multiply
    always_comb begin
        cnt_d = md_op[1] ? C_DIV_LOAD : C_MULT_LOAD;
    end

    // Sequencer FSM: operand latches, countdown, HI/LO commit and MTHI/MTLO writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (is_long_op(md_op)) begin
                            op_q    <= md_op;
                            a_q     <= src_a;
                            b_q     <= src_b;
                            cnt_q   <= cnt_d;
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end else if (md_op == MD_MTHI) begin
                            hi_q <= src_a;
                        end else if (md_op == MD_MTLO) begin
                            lo_q <= src_a;
                        end
                    end
                end
                ST_RUN: begin
                    // Any start here is ignored; the hazard unit prevents it
                    if (cnt_q == C_CNT_ONE) begin
                        hi_q    <= w_result[63:32];
                        lo_q    <= w_result[31:0];
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - C_CNT_ONE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    // Stall must cover the start cycle itself, before busy rises
    assign stall_req = d_md_use & (busy_q | (start & is_long_op(md_op)));

endmodule : md_sequencer
`default_nettype wire

// File: tb/tb_md_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_md_sequencer
// Purpose  : Scoreboard bench for md_sequencer. Stimulus pushes expected
//            {hi,lo} and busy length; a negedge monitor pops on each commit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_md_sequencer;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          n;
        int          tag;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   run_len = 0;
    logic busy_prev = 1'b0;

    md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .md_op     (md_op),
        .src_a     (src_a),
        .src_b     (src_b),
        .d_md_use  (d_md_use),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Commit monitor: on each busy falling edge compare against the scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            run_len   = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy) run_len++;
            if (busy_prev && !busy) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_commit: got hi=%h lo=%h expected no commit", hi, lo);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check32($sformatf("op%0d_hi", e.tag), hi, e.hi);
                    check32($sformatf("op%0d_lo", e.tag), lo, e.lo);
                    check32($sformatf("op%0d_busy_len", e.tag), run_len, e.n);
                end
                run_len = 0;
            end
            busy_prev = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one long op, scramble operands afterwards, and track stall until done
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_md, input logic [31:0] eh, input logic [31:0] el,
                          input int n, input int tag);
        int k;
        sb.push_back('{hi: eh, lo: el, n: n, tag: tag});
        start = 1'b1; md_op = op; src_a = a; src_b = b; d_md_use = use_md;
        #1;
        check32($sformatf("op%0d_stall_start", tag), {31'd0, stall_req}, {31'd0, use_md});
        tick();
        start = 1'b0; src_a = 32'hDEAD_BEEF; src_b = 32'h0000_0003;
        k = 0;
        while (busy && k < 40) begin
            check32($sformatf("op%0d_stall_busy", tag), {31'd0, stall_req}, {31'd0, use_md});
            tick();
            k++;
        end
        if (k >= 40) begin
            checks++; errors++;
            $display("FAIL op%0d_timeout: got busy=%b after 40 cycles expected 0", tag, busy);
        end
        check32($sformatf("op%0d_stall_after", tag), {31'd0, stall_req}, 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b1; md_op = 3'd0; src_a = 32'd5; src_b = 32'd5; d_md_use = 1'b0;
        repeat (3) tick();
        check32("rst_busy", {31'd0, busy}, 32'd0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        start = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check32("post_rst_busy", {31'd0, busy}, 32'd0);
        check32("post_rst_hi", hi, 32'd0);
        check32("post_rst_lo", lo, 32'd0);

        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 5, 1);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE, 5, 2);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 3);
        run_op(3'd3, 32'd7, 32'd0, 1'b0, 32'h0000_0007, 32'hFFFF_FFFF, 10, 4);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000, 32'h8000_0000, 10, 5);
        run_op(3'd2, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 10, 6);
        run_op(3'd3, 32'hFFFF_FFFF, 32'd10, 1'b0, 32'h0000_0005, 32'h1999_9999, 10, 7);
        run_op(3'd2, 32'hFFFF_FFFB, 32'd0, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, 8);

        // MTHI / MTLO in IDLE
        start = 1'b1; md_op = 3'd4; src_a = 32'h0000_1234; src_b = 32'd0; d_md_use = 1'b1;
        #1;
        check32("mthi_stall", {31'd0, stall_req}, 32'd0);
        tick();
        start = 1'b0;
        check32("mthi_hi", hi, 32'h0000_1234);
        check32("mthi_lo_kept", lo, 32'hFFFF_FFFF);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        start = 1'b1; md_op = 3'd5; src_a = 32'h0000_5678;
        tick();
        start = 1'b0;
        check32("mtlo_lo", lo, 32'h0000_5678);
        check32("mtlo_hi_kept", hi, 32'h0000_1234);
        // op 6 is a no-op
        start = 1'b1; md_op = 3'd6; src_a = 32'hAAAA_AAAA;
        tick();
        start = 1'b0; d_md_use = 1'b0;
        check32("op6_hi", hi, 32'h0000_1234);
        check32("op6_lo", lo, 32'h0000_5678);
        check32("op6_busy", {31'd0, busy}, 32'd0);

        // MULT, then MTLO and MULT arriving while RUN must be ignored
        sb.push_back('{hi: 32'hFFFF_FFFF, lo: 32'hFFFF_FFEB, n: 5, tag: 9});
        start = 1'b1; md_op = 3'd0; src_a = 32'hFFFF_FFFD; src_b = 32'd7;
        tick();
        start = 1'b1; md_op = 3'd5; src_a = 32'h0BAD_0BAD;
        tick();
        start = 1'b1; md_op = 3'd0; src_a = 32'd1; src_b = 32'd1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        check32("ignore_busy_done", {31'd0, busy}, 32'd0);

        // Reset during DIV aborts with no later commit
        start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd3;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        check32("abort_busy", {31'd0, busy}, 32'd0);
        check32("abort_hi", hi, 32'd0);
        check32("abort_lo", lo, 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (14) tick();
        check32("abort_no_commit_hi", hi, 32'd0);
        check32("abort_no_commit_lo", lo, 32'd0);
        check32("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_md_sequencer
`default_nettype wire
